// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_pkg
//  Description : Shared types and constants for the loadable instruction
//                memory (controller state encoding, NOP word, default sizes
//                shared with the fetch stage, optional parity width).
//                Optional feature macro: IMEM_PARITY_EN
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } imem_state_t;

    // Defaults shared with the fetch stage
    localparam int DEF_ADDR_W = 20;
    localparam int DEF_WORD_W = 32;
    localparam int DEF_DEPTH  = 1024;
    localparam int DEF_CNT_W  = 11;

    // Word returned for out-of-range fetches
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Number of check bits stored alongside each instruction word
`ifdef IMEM_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif

endpackage : imem_pkg
`default_nettype wire

// File: rtl/imem_bank.sv
`default_nettype none
// ============================================================================
//  Module      : imem_bank
//  Description : Plain synchronous storage array, one write port and one
//                read port. The array itself is never cleared; only the
//                read-data register is reset so fetch outputs start at zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_bank #(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 10
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Write port: contents survive reset
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port: registered, holds its value between reads
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : imem_bank
`default_nettype wire

// File: rtl/instruction_memory_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_memory_ctrl
//  Description : Loadable instruction memory for the fetch stage. A streamed
//                load port writes the program at run time; a registered
//                fetch port (latency 1) returns words with range checking.
//                Optional feature macro: IMEM_PARITY_EN (even parity per
//                word, parity mismatch raises fetch_fault and sticky
//                parity_err).
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_memory_ctrl
    import imem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int WORD_W = DEF_WORD_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_start_i,
    input  logic              load_valid_i,
    input  logic              load_last_i,
    input  logic [WORD_W-1:0] load_data_i,
    output logic              load_ready_o,
    output logic              load_done_o,
    output logic [CNT_W-1:0]  load_count_o,
    input  logic              fetch_req_i,
    input  logic [ADDR_W-1:0] fetch_addr_i,
    output logic              fetch_ready_o,
    output logic              fetch_valid_o,
    output logic [WORD_W-1:0] instruction_o,
    output logic              fetch_fault_o,
    output logic              parity_err_o
);

    localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              MEM_W     = WORD_W + PAR_W;
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_PTR = CNT_W'(DEPTH - 1);

    imem_state_t       state_q;
    logic [CNT_W-1:0]  wr_ptr_q;
    logic              load_done_q;
    logic              fetch_valid_q;
    logic              range_fault_q;

    logic              w_load_wr;
    logic              w_last_wr;
    logic              w_fetch_acc;
    logic              w_in_range;
    logic              w_par_bad;
    logic [MEM_W-1:0]  w_wdata;
    logic [MEM_W-1:0]  w_rdata;

    // load_start takes priority over both handshakes in the same cycle, so a
    // restart never also consumes a load word or a fetch request.
    assign load_ready_o  = (state_q == LOAD) & ~load_start_i;
    assign fetch_ready_o = (state_q == RUN)  & ~load_start_i;

    assign w_load_wr   = load_valid_i & load_ready_o;
    assign w_last_wr   = w_load_wr & (load_last_i | (wr_ptr_q == LAST_PTR));
    assign w_fetch_acc = fetch_req_i & fetch_ready_o;
    // Full-width compare: upper address bits must not alias into the array
    assign w_in_range  = ({1'b0, fetch_addr_i} < DEPTH_EXT);

`ifdef IMEM_PARITY_EN
    logic par_chk_q;
    logic parity_err_q;

    assign w_wdata      = {^load_data_i, load_data_i};
    // Only words actually read from the array are parity checked
    assign w_par_bad    = par_chk_q & (^w_rdata);
    assign parity_err_o = parity_err_q | (fetch_valid_q & w_par_bad);

    // Remember whether the held read data came from the array; latch errors
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            par_chk_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            if (w_fetch_acc) begin
                par_chk_q <= w_in_range;
            end
            if (fetch_valid_q & w_par_bad) begin
                parity_err_q <= 1'b1;
            end
        end
    end
`else
    assign w_wdata      = load_data_i;
    assign w_par_bad    = 1'b0;
    assign parity_err_o = 1'b0;
`endif

    // Controller FSM: load sequencing, word pointer and completion pulse
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            load_done_q <= 1'b0;
        end else begin
            load_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load_start_i) begin
                        state_q  <= LOAD;
                        wr_ptr_q <= '0;
                    end
                end
                LOAD: begin
                    if (load_start_i) begin
                        wr_ptr_q <= '0;
                    end else if (w_load_wr) begin
                        wr_ptr_q <= wr_ptr_q + CNT_W'(1);
                        if (w_last_wr) begin
                            state_q     <= RUN;
                            load_done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (load_start_i) begin
                        state_q  <= LOAD;
                        wr_ptr_q <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Fetch response: valid strobe and held range-fault flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_valid_q <= 1'b0;
            range_fault_q <= 1'b0;
        end else begin
            fetch_valid_q <= w_fetch_acc;
            if (w_fetch_acc) begin
                range_fault_q <= ~w_in_range;
            end
        end
    end

    imem_bank #(
        .DEPTH  (DEPTH),
        .DATA_W (MEM_W),
        .IDX_W  (IDX_W)
    ) u_bank (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (w_load_wr),
        .waddr_i (wr_ptr_q[IDX_W-1:0]),
        .wdata_i (w_wdata),
        .re_i    (w_fetch_acc & w_in_range),
        .raddr_i (fetch_addr_i[IDX_W-1:0]),
        .rdata_o (w_rdata)
    );

    assign load_done_o   = load_done_q;
    assign load_count_o  = wr_ptr_q;
    assign fetch_valid_o = fetch_valid_q;
    assign instruction_o = range_fault_q ? WORD_W'(NOP_WORD) : w_rdata[WORD_W-1:0];
    assign fetch_fault_o = range_fault_q | w_par_bad;

endmodule : instruction_memory_ctrl
`default_nettype wire
